// File: rtl/spi_mnrch_gen.sv
// spi_mnrch_gen: SPI mode-3 master with configurable word width, SCLK
// divider (period 2^DIV_LOG2 clk cycles) and one-hot slave-select fan-out.
// SCLK idles high, MOSI changes on SCLK falling edges and MISO is sampled
// on SCLK rising edges.
// Build option: define SPI_MNRCH_LSB_FIRST_EN to send/receive LSB first;
// the default build is MSB first. Timing is the same in both builds.
module spi_mnrch_gen #(
    parameter int  DATA_W   = 16,
    parameter int  DIV_LOG2 = 4,
    parameter int  NUM_SS   = 1,
    localparam int SW       = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wrt,
    input  logic [DATA_W-1:0] wt_data,
    input  logic [SW-1:0]     ss_sel,
    input  logic              MISO,
    output logic              MOSI,
    output logic              SCLK,
    output logic [NUM_SS-1:0] SS_n,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rd_data
);

    typedef enum logic [1:0] {IDLE, FRONT, TRANSMIT, BACK} state_t;

    // Value of the rising-edge counter when the last bit of the word is sampled.
    localparam logic [4:0] LAST_BIT = 5'(DATA_W - 1);

    state_t              state;
    state_t              state_nxt;
    logic [DIV_LOG2-1:0] div_cnt;
    logic [4:0]          bit_cnt;
    logic [DATA_W-1:0]   shft;
    logic                smpl;
    logic [SW-1:0]       ss_q;

    logic accept;
    logic shift_en;
    logic sample_en;
    logic done_set;
    logic fall_nxt;
    logic rise_nxt;

    // The divider MSB is the SCLK phase: the next edge sets it (SCLK falls)
    // when the low bits are all ones, and wraps it (SCLK rises) at all ones.
    assign fall_nxt = ~div_cnt[DIV_LOG2-1] & (&div_cnt[DIV_LOG2-2:0]);
    assign rise_nxt = &div_cnt;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and the per-cycle strobes for the datapath.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        shift_en  = 1'b0;
        sample_en = 1'b0;
        done_set  = 1'b0;
        case (state)
            IDLE: begin
                if (wrt) begin
                    accept    = 1'b1;
                    state_nxt = FRONT;
                end
            end
            FRONT: begin
                // The first falling edge only starts the bit clock; the first
                // bit is already on MOSI, so nothing is shifted here.
                if (fall_nxt) begin
                    state_nxt = TRANSMIT;
                end
            end
            TRANSMIT: begin
                if (fall_nxt) begin
                    shift_en = 1'b1;
                end
                if (rise_nxt) begin
                    sample_en = 1'b1;
                    if (bit_cnt == LAST_BIT) begin
                        state_nxt = BACK;
                    end
                end
            end
            BACK: begin
                // The last sample has no falling edge of its own; it is
                // shifted in as the slave select is released.
                if (fall_nxt) begin
                    shift_en  = 1'b1;
                    done_set  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Divider, bit counter, shift register, MISO sample, slave index and done flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
            bit_cnt <= '0;
            shft    <= '0;
            smpl    <= 1'b0;
            ss_q    <= '0;
            done    <= 1'b0;
        end else begin
            if (state == IDLE) begin
                div_cnt <= '0;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end

            if (accept) begin
                bit_cnt <= '0;
            end else if (sample_en) begin
                bit_cnt <= bit_cnt + 5'd1;
            end

            if (accept) begin
                shft <= wt_data;
                ss_q <= ss_sel;
            end else if (shift_en) begin
`ifdef SPI_MNRCH_LSB_FIRST_EN
                shft <= {smpl, shft[DATA_W-1:1]};
`else
                shft <= {shft[DATA_W-2:0], smpl};
`endif
            end

            if (sample_en) begin
                smpl <= MISO;
            end

            if (done_set) begin
                done <= 1'b1;
            end else if (accept) begin
                done <= 1'b0;
            end
        end
    end

    // Slave select: only the latched index is driven low while a transfer runs;
    // an index beyond the fan-out matches no output.
    always_comb begin
        SS_n = '1;
        if (state != IDLE) begin
            for (int i = 0; i < NUM_SS; i++) begin
                if (ss_q == SW'(i)) begin
                    SS_n[i] = 1'b0;
                end
            end
        end
    end

    assign SCLK    = ~((state == TRANSMIT) & div_cnt[DIV_LOG2-1]);
    assign busy    = (state != IDLE);
    assign rd_data = shft;
`ifdef SPI_MNRCH_LSB_FIRST_EN
    assign MOSI    = shft[0];
`else
    assign MOSI    = shft[DATA_W-1];
`endif

endmodule
